// File: rtl/exhaustive_vector_sequencer_pkg.sv
// exhaustive_vector_sequencer_pkg: sweep FSM states and MISR constants
package exhaustive_seq_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, EMIT, DONE} state_t;
  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
endpackage

// File: rtl/exhaustive_vector_sequencer_if.sv
// exhaustive_vector_sequencer_if: record stream handshake to the capture host
interface exhaustive_vector_sequencer_if #(parameter int N_IN = 8, parameter int N_OUT = 1);
  logic rec_valid;
  logic rec_ready;
  logic [N_IN-1:0] rec_vector;
  logic [N_OUT-1:0] rec_response;
  modport master(output rec_valid, rec_vector, rec_response, input rec_ready);
  modport slave(input rec_valid, rec_vector, rec_response, output rec_ready);
endinterface

// File: rtl/exhaustive_vector_sequencer_misr16.sv
// misr16: 16-bit response signature register with clear and enable
module misr16
  import exhaustive_seq_pkg::*;
#(
  parameter int N_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] din,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(din);
endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// exhaustive_vector_sequencer: drives every input vector, samples and streams responses
module exhaustive_vector_sequencer
  import exhaustive_seq_pkg::*;
#(
  parameter int N_IN          = 8,
  parameter int N_OUT         = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         CK,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  output logic [N_IN-1:0]              dut_in,
  input  logic [N_OUT-1:0]             dut_out,
  exhaustive_vector_sequencer_if.master rec,
  output logic                         busy,
  output logic                         done,
  output logic [SIG_W-1:0]             signature,
  output logic [N_IN:0]                vec_count
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
    $error("SETTLE_CYCLES must be within 1..15");
  end
  state_t state, state_n;
  logic [3:0] settle_cnt;
  logic idle_or_done, last, launch;
  assign idle_or_done = state == IDLE || state == DONE;
  assign last = &dut_in;
  assign launch = idle_or_done && start && !abort;
  assign busy = !idle_or_done;
  assign done = state == DONE;
  assign rec.rec_valid = state == EMIT;
  always_ff @(posedge CK) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = APPLY;
      APPLY:      state_n = SETTLE;
      SETTLE:     if (settle_cnt == '0) state_n = CAPTURE;
      CAPTURE:    state_n = EMIT;
      EMIT:       if (rec.rec_ready) state_n = last ? DONE : APPLY;
      default:    state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // dut_in doubles as the sweep vector register; it stops at all ones instead of wrapping
  always_ff @(posedge CK)
    if (reset) begin
      dut_in <= '0;
      settle_cnt <= '0;
      vec_count <= '0;
      rec.rec_vector <= '0;
      rec.rec_response <= '0;
    end else if (abort) dut_in <= '0;
    else begin
      if (launch) begin
        dut_in <= '0;
        vec_count <= '0;
      end
      if (state == APPLY) settle_cnt <= 4'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 4'd1;
      if (state == CAPTURE) begin
        rec.rec_response <= dut_out;
        rec.rec_vector <= dut_in;
      end
      if (state == EMIT && rec.rec_ready) begin
        vec_count <= vec_count + (N_IN + 1)'(1);
        if (!last) dut_in <= dut_in + N_IN'(1);
      end
    end
  misr16 #(.N_OUT(N_OUT)) u_misr (
    .clk(CK),
    .rst(reset),
    .clr(launch),
    .en(state == CAPTURE && !abort),
    .din(dut_out),
    .sig(signature)
  );
endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// tb_exhaustive_vector_sequencer: directed checks of sweep order, timing, handshake, abort and reset
module tb_exhaustive_vector_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  logic a_start = 1'b0, a_abort = 1'b0, a_busy, a_done;
  logic [1:0] a_in;
  logic [15:0] a_sig;
  logic [2:0] a_cnt;
  exhaustive_vector_sequencer_if #(.N_IN(2), .N_OUT(1)) ia ();
  exhaustive_vector_sequencer #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(1)) u_a (
    .CK(clk), .reset(reset), .start(a_start), .abort(a_abort), .dut_in(a_in), .dut_out(1'b1),
    .rec(ia), .busy(a_busy), .done(a_done), .signature(a_sig), .vec_count(a_cnt));

  logic b_start = 1'b0, b_abort = 1'b0, b_mode = 1'b0, b_busy, b_done, b_out;
  logic [7:0] b_in;
  logic [15:0] b_sig;
  logic [8:0] b_cnt;
  assign b_out = b_mode & ^b_in;
  exhaustive_vector_sequencer_if #(.N_IN(8), .N_OUT(1)) ib ();
  exhaustive_vector_sequencer u_b (
    .CK(clk), .reset(reset), .start(b_start), .abort(b_abort), .dut_in(b_in), .dut_out(b_out),
    .rec(ib), .busy(b_busy), .done(b_done), .signature(b_sig), .vec_count(b_cnt));

  logic c_start = 1'b0, c_busy, c_done;
  logic [2:0] c_in;
  logic [1:0] c_d1, c_d2;
  logic [15:0] c_sig;
  logic [3:0] c_cnt;
  always @(posedge clk) begin
    c_d1 <= {c_in[2] ^ c_in[1], c_in[0]};
    c_d2 <= c_d1;
  end
  exhaustive_vector_sequencer_if #(.N_IN(3), .N_OUT(2)) ic ();
  exhaustive_vector_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE_CYCLES(3)) u_c (
    .CK(clk), .reset(reset), .start(c_start), .abort(1'b0), .dut_in(c_in), .dut_out(c_d2),
    .rec(ic), .busy(c_busy), .done(c_done), .signature(c_sig), .vec_count(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, d};
  endfunction

  initial begin
    int n, k, bad;
    logic [15:0] m;
    logic [15:0] sig1 [4];
    logic [2:0] kv;
    sig1 = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    ia.rec_ready = 1'b1;
    ib.rec_ready = 1'b1;
    ic.rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_valid", ib.rec_valid, 0);
    chk("rst_sig", b_sig, 0);
    chk("rst_cnt", b_cnt, 0);
    chk("rst_dut_in", b_in, 0);
    chk("rst_vec", ib.rec_vector, 0);
    chk("rst_resp", ib.rec_response, 0);
    reset = 1'b0;
    // four-vector sweep with a constant-one response
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n = 1;
    k = 0;
    while (!a_done && n < 64) begin
      if (ia.rec_valid) begin
        chk("t1_vec", ia.rec_vector, k);
        chk("t1_resp", ia.rec_response, 1);
        chk("t1_sig", a_sig, k < 4 ? sig1[k] : 16'hxxxx);
        k++;
      end
      @(negedge clk) n++;
    end
    chk("t1_latency", n - 1, 16);
    chk("t1_records", k, 4);
    chk("t1_cnt", a_cnt, 4);
    chk("t1_sig_final", a_sig, 16'h000F);
    chk("t1_dut_in_held", a_in, 2'b11);
    chk("t1_busy", a_busy, 0);
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("t1_abort_wins_done", a_done, 0);
    chk("t1_abort_wins_busy", a_busy, 0);
    // full default sweep with zero response
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 1;
    k = 0;
    bad = 0;
    while (!b_done && n < 1100) begin
      if (ib.rec_valid) begin
        if (ib.rec_vector !== 8'(k)) bad++;
        k++;
      end
      @(negedge clk) n++;
    end
    chk("t2_latency", n - 1, 1024);
    chk("t2_order_errors", bad, 0);
    chk("t2_records", k, 256);
    chk("t2_cnt", b_cnt, 256);
    chk("t2_sig", b_sig, 0);
    // backpressure on vector 0x2A with parity response
    b_mode = 1'b1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 0;
    while (!(ib.rec_valid && ib.rec_vector === 8'h2A) && n < 400) @(negedge clk) n++;
    chk("t3_reach_2a", ib.rec_vector, 8'h2A);
    ib.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", ib.rec_valid, 1);
      chk("t3_hold_vec", ib.rec_vector, 8'h2A);
      chk("t3_hold_resp", ib.rec_response, 1);
      chk("t3_hold_cnt", b_cnt, 42);
    end
    ib.rec_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept_cnt", b_cnt, 43);
    chk("t3_accept_valid", ib.rec_valid, 0);
    chk("t3_next_dut_in", b_in, 8'h2B);
    n = 0;
    while (!ib.rec_valid && n < 10) @(negedge clk) n++;
    chk("t3_next_vec", ib.rec_vector, 8'h2B);
    chk("t3_next_cnt", b_cnt, 43);
    b_abort = 1'b1;
    @(negedge clk) b_abort = 1'b0;
    chk("t3_abort_busy", b_busy, 0);
    // abort in SETTLE of vector 0x10
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 0;
    while (b_in !== 8'h10 && n < 200) @(negedge clk) n++;
    @(negedge clk);
    chk("t4_settle_busy", b_busy, 1);
    chk("t4_settle_valid", ib.rec_valid, 0);
    b_abort = 1'b1;
    @(negedge clk) b_abort = 1'b0;
    m = '0;
    for (int v = 0; v < 16; v++) m = misr(m, ^8'(v));
    chk("t4_busy", b_busy, 0);
    chk("t4_valid", ib.rec_valid, 0);
    chk("t4_done", b_done, 0);
    chk("t4_dut_in", b_in, 0);
    chk("t4_cnt", b_cnt, 16);
    chk("t4_sig_partial", b_sig, m);
    @(negedge clk);
    chk("t4_stays_idle", b_busy, 0);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    chk("t4_restart_busy", b_busy, 1);
    chk("t4_restart_dut_in", b_in, 0);
    chk("t4_restart_cnt", b_cnt, 0);
    chk("t4_restart_sig", b_sig, 0);
    n = 0;
    while (!ib.rec_valid && n < 10) @(negedge clk) n++;
    chk("t4_restart_vec", ib.rec_vector, 0);
    b_abort = 1'b1;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_abort = 1'b0;
    b_start = 1'b0;
    chk("t4_abort_wins_idle", b_busy, 0);
    // reset during EMIT of vector 7
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 0;
    while (!(ib.rec_valid && ib.rec_vector === 8'h07) && n < 100) @(negedge clk) n++;
    chk("t5_reach_7", ib.rec_vector, 8'h07);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("t5_valid", ib.rec_valid, 0);
    chk("t5_busy", b_busy, 0);
    chk("t5_done", b_done, 0);
    chk("t5_sig", b_sig, 0);
    chk("t5_cnt", b_cnt, 0);
    chk("t5_dut_in", b_in, 0);
    chk("t5_vec", ib.rec_vector, 0);
    chk("t5_resp", ib.rec_response, 0);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 1;
    while (!b_done && n < 1100) begin
      b_start = n == 20;
      @(negedge clk) n++;
    end
    b_start = 1'b0;
    m = '0;
    for (int v = 0; v < 256; v++) m = misr(m, ^8'(v));
    chk("t5_latency", n - 1, 1024);
    chk("t5_cnt", b_cnt, 256);
    chk("t5_sig_full", b_sig, m);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    chk("t5_fresh_sig", b_sig, 0);
    chk("t5_fresh_done", b_done, 0);
    chk("t5_fresh_busy", b_busy, 1);
    b_abort = 1'b1;
    @(negedge clk) b_abort = 1'b0;
    // settle of three cycles against a two-cycle-latency DUT
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    n = 1;
    k = 0;
    while (!c_done && n < 100) begin
      if (ic.rec_valid) begin
        kv = 3'(k);
        chk("t6_vec", ic.rec_vector, kv);
        chk("t6_resp", ic.rec_response, {kv[2] ^ kv[1], kv[0]});
        k++;
      end
      @(negedge clk) n++;
    end
    chk("t6_latency", n - 1, 48);
    chk("t6_records", k, 8);
    chk("t6_cnt", c_cnt, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
